change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream stage of the soda vending FSM. Consumes its registered soda/change outputs and turns each vend request into timed actuator drive: one vend-motor pulse, then one ejector pulse per nickel of change.
- The upstream FSM has no backpressure, so this block buffers one pending request while busy.
- It flags any request it cannot honour.
- `change_i` counts nickels: value N means N×5c of change, legal range 0..4.

Parameters:
- VEND_LEN, 4, cycles `vend_o` is held high per vend (≥1)
- PULSE_LEN, 3, cycles `nickel_eject_o` is held high per nickel (≥1)
- GAP_LEN, 2, low cycles after each nickel pulse (≥1)
- CNT_W, 16, width of the vend statistics counter

Ports:
- clk_i  in  1  clock; all logic is rising-edge
- rst_i  in  1  synchronous, active-high reset
- soda_i  in  1  vend request, sampled every cycle; 1 = request present this cycle
- change_i  in  3  nickels to return with the request; legal range 0..4
- vend_o  out  1  vend-motor drive
- nickel_eject_o  out  1  coin-ejector drive, one pulse per nickel
- busy_o  out  1  high while any request is being serviced
- pend_o  out  1  pending slot occupied
- err_o  out  1  sticky: a request was dropped or carried illegal change
- vend_cnt_o  out  CNT_W  number of vends started; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_i=1 at an edge):
  - Next state is IDLE.
  - All outputs go to 0, `vend_cnt_o` = 0, pending slot cleared, timers and counters cleared.
  - Applies mid-operation: any actuator pulse is cut off on the following cycle.
- Request event: `soda_i`=1 sampled at an edge.
  - `soda_i`=0 with `change_i`≠0: illegal. Set `err_o`; no action.
  - `change_i` in 5..7: saturate to 4 and set `err_o`.
- State machine, one timer, 3-bit nickel counter `nrem`:
  - IDLE: on a request, load `nrem` and the timer, increment `vend_cnt_o`, go to VEND. `vend_o` rises the cycle after the request edge; 1-cycle latency.
  - VEND: `vend_o`=1 for VEND_LEN cycles. Then go to EJ_HI if `nrem`>0, otherwise complete.
  - EJ_HI: `nickel_eject_o`=1 for PULSE_LEN cycles, then decrement `nrem` and go to EJ_LO.
  - EJ_LO: both actuators low for GAP_LEN cycles. Then go to EJ_HI if `nrem`>0, otherwise complete.
- Complete: taken at the last cycle's edge of VEND or EJ_LO.
  - If the pending slot is full: load it, clear `pend_o`, increment the counter, go to VEND. There is no idle gap.
  - Else if a new request arrives at that same edge: load it directly into VEND.
  - Otherwise go to IDLE.
- Requests while busy (including the completion edge when the slot is occupied):
  - Slot empty: store {`change_i`} and set `pend_o`.
  - Slot full: drop the request and set `err_o`.
  - A completion edge that pops the slot and receives a request at once stores the new request into the freed slot.
- `busy_o` = (state≠IDLE).
- `vend_o` and `nickel_eject_o` are never high together.
- `err_o` clears only on reset.
- Outputs are registered; no combinational path from inputs to outputs.
- Counter wraps silently from all-ones to 0.

Test Plan:
- Reset, then request change=2 at edge 0. Required response:
  - `vend_o` high cycles 1–4
  - `nickel_eject_o` high 5–7, low 8–9, high 10–12, low 13–14
  - `busy_o` high 1–14, low at 15
  - `vend_cnt_o`=1
- Request change=0 → `vend_o` high 1–4, no eject pulses, IDLE at cycle 5, `err_o`=0.
- Request change=4 at 0; second request change=1 at cycle 3; third at cycle 6 → second pended (`pend_o`=1 from cycle 4), third dropped with `err_o`=1. Second vend begins the cycle immediately after the first job's final gap cycle, with no IDLE cycle. `vend_cnt_o`=2.
- Request change=1 arriving exactly at the completion edge of a prior job with the slot empty → `vend_o` high the next cycle, `pend_o` stays 0.
- Request change=7 → exactly 4 nickel pulses, `err_o`=1. `soda_i`=0 with `change_i`=3 → no actuation, `err_o`=1.
- Assert rst_i during the 2nd EJ_HI cycle with a request pending → all outputs 0 the next cycle, `pend_o`=0, `vend_cnt_o`=0. A subsequent request behaves exactly as in scenario 1.

Source files
------------

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Converts vend requests from the soda FSM into timed actuator
//            drive. Each request gives one vend-motor pulse, then one ejector
//            pulse per nickel of change. One request can wait in a pending
//            slot while a job runs. Any request that cannot be honoured sets a
//            sticky error flag.
// Ports    : clk_i          - rising-edge clock
//            rst_i          - synchronous active-high reset
//            soda_i         - vend request, sampled every edge
//            change_i[2:0]  - nickels to return (legal 0..4)
//            vend_o         - vend-motor drive
//            nickel_eject_o - coin-ejector drive, one pulse per nickel
//            busy_o         - a request is being serviced
//            pend_o         - pending slot occupied
//            err_o          - sticky error (dropped or illegal request)
//            vend_cnt_o     - vends started, wraps modulo 2^CNT_W
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int VEND_LEN  = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             soda_i,
  input  logic [2:0]       change_i,
  output logic             vend_o,
  output logic             nickel_eject_o,
  output logic             busy_o,
  output logic             pend_o,
  output logic             err_o,
  output logic [CNT_W-1:0] vend_cnt_o
);

  // A single timer serves every phase, so it is sized for the longest one.
  localparam int c_max_a   = (VEND_LEN > PULSE_LEN) ? VEND_LEN : PULSE_LEN;
  localparam int c_max_len = (c_max_a > GAP_LEN) ? c_max_a : GAP_LEN;
  localparam int c_tmr_w   = (c_max_len > 1) ? $clog2(c_max_len) : 1;

  // The timer is loaded with LEN-1 and the phase ends on the cycle it reads 0.
  localparam logic [c_tmr_w-1:0] c_vend_ld  = c_tmr_w'(VEND_LEN - 1);
  localparam logic [c_tmr_w-1:0] c_pulse_ld = c_tmr_w'(PULSE_LEN - 1);
  localparam logic [c_tmr_w-1:0] c_gap_ld   = c_tmr_w'(GAP_LEN - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_vend  = 2'd1;
  localparam logic [1:0] c_st_ej_hi = 2'd2;
  localparam logic [1:0] c_st_ej_lo = 2'd3;

  logic [1:0]         r_state,    w_state_nx;
  logic [c_tmr_w-1:0] r_timer,    w_timer_nx;
  logic [2:0]         r_nrem,     w_nrem_nx;
  logic               r_pend,     w_pend_nx;
  logic [2:0]         r_pend_chg, w_pend_chg_nx;
  logic               r_err,      w_err_nx;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nx;

  logic       w_chg_sat;
  logic [2:0] w_chg;
  logic       w_done;
  logic       w_load;
  logic [2:0] w_load_chg;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= c_st_idle;
      r_timer    <= '0;
      r_nrem     <= '0;
      r_pend     <= 1'b0;
      r_pend_chg <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_timer    <= w_timer_nx;
      r_nrem     <= w_nrem_nx;
      r_pend     <= w_pend_nx;
      r_pend_chg <= w_pend_chg_nx;
      r_err      <= w_err_nx;
      r_cnt      <= w_cnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_chg_sat     = (change_i > 3'd4);
    w_chg         = w_chg_sat ? 3'd4 : change_i;
    w_state_nx    = r_state;
    w_timer_nx    = r_timer;
    w_nrem_nx     = r_nrem;
    w_pend_nx     = r_pend;
    w_pend_chg_nx = r_pend_chg;
    w_err_nx      = r_err;
    w_cnt_nx      = r_cnt;
    w_done        = 1'b0;
    w_load        = 1'b0;
    w_load_chg    = w_chg;

    // Change without a request, or change beyond four nickels, is flagged.
    if ((!soda_i && (change_i != 3'd0)) || (soda_i && w_chg_sat)) begin
      w_err_nx = 1'b1;
    end

    case (r_state)
      c_st_idle: begin
        if (soda_i) begin
          w_load = 1'b1;
        end
      end
      c_st_vend: begin
        if (r_timer == '0) begin
          if (r_nrem != 3'd0) begin
            w_state_nx = c_st_ej_hi;
            w_timer_nx = c_pulse_ld;
          end else begin
            w_done = 1'b1;
          end
        end else begin
          w_timer_nx = r_timer - c_tmr_one;
        end
      end
      c_st_ej_hi: begin
        if (r_timer == '0) begin
          w_state_nx = c_st_ej_lo;
          w_timer_nx = c_gap_ld;
          w_nrem_nx  = r_nrem - 3'd1;
        end else begin
          w_timer_nx = r_timer - c_tmr_one;
        end
      end
      default: begin
        if (r_timer == '0) begin
          if (r_nrem != 3'd0) begin
            w_state_nx = c_st_ej_hi;
            w_timer_nx = c_pulse_ld;
          end else begin
            w_done = 1'b1;
          end
        end else begin
          w_timer_nx = r_timer - c_tmr_one;
        end
      end
    endcase

    if (r_state != c_st_idle) begin
      if (w_done) begin
        if (r_pend) begin
          // Pop the slot; a request arriving on this edge refills it.
          w_load     = 1'b1;
          w_load_chg = r_pend_chg;
          if (soda_i) begin
            w_pend_chg_nx = w_chg;
          end else begin
            w_pend_nx = 1'b0;
          end
        end else if (soda_i) begin
          w_load = 1'b1;
        end else begin
          w_state_nx = c_st_idle;
        end
      end else if (soda_i) begin
        if (!r_pend) begin
          w_pend_nx     = 1'b1;
          w_pend_chg_nx = w_chg;
        end else begin
          w_err_nx = 1'b1;
        end
      end
    end

    if (w_load) begin
      w_state_nx = c_st_vend;
      w_timer_nx = c_vend_ld;
      w_nrem_nx  = w_load_chg;
      w_cnt_nx   = r_cnt + c_cnt_one;
    end
  end

  // Output decode, driven only from flops
  always_comb begin
    vend_o         = (r_state == c_st_vend);
    nickel_eject_o = (r_state == c_st_ej_hi);
    busy_o         = (r_state != c_st_idle);
    pend_o         = r_pend;
    err_o          = r_err;
    vend_cnt_o     = r_cnt;
  end

endmodule
`default_nettype wire
